// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_arbiter                                                    |
// | Desc    : Four-master round-robin bus arbiter. Active-low requests and   |
// |           registered active-low grants; a grant is held until its owner |
// |           releases the request. Handover to the next requester happens |
// |           on the release edge with no dead cycle.                       |
// |           Optional macro BUS_ARB_TIMEOUT_EN adds a per-owner hold limit |
// |           of ARB_TIMEOUT cycles when other masters are waiting.         |
// | Rev     : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

module bus_arbiter #(
   parameter int ARB_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0] state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] last_q,  last_d;
   logic [3:0] grnt_q,  grnt_d;     // active-low, bit i = master i

   logic [3:0] req;                 // active-high view of the requests
   logic [3:0] others;              // requesters other than the current owner
   logic [1:0] win;
   logic       take_new;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int              CNT_W     = (ARB_TIMEOUT > 2) ? $clog2(ARB_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(ARB_TIMEOUT - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   // Hold limit is not built; keep the parameter referenced for a stable interface.
   localparam int c_unused_timeout = ARB_TIMEOUT;
`endif

   assign req = {m3_req_ == `ENABLE_, m2_req_ == `ENABLE_,
                 m1_req_ == `ENABLE_, m0_req_ == `ENABLE_};
   assign others = req & ~(4'b0001 << owner_q);

   // First requester found scanning ptr+1, ptr+2, ptr+3, then ptr itself.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] sel;
      logic       found;
      sel   = ptr;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr + i[1:0];
         if (!found && r[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Active-low one-hot grant vector for a winning master.
   function automatic logic [3:0] grant_vec(input logic [1:0] w);
      logic [3:0] g;
      for (int i = 0; i < 4; i++) begin
         g[i] = (w == i[1:0]) ? `ENABLE_ : `DISABLE_;
      end
      return g;
   endfunction

   // Next-state logic: arbitration, hold, handover and release to idle.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      grnt_d   = grnt_q;
      win      = owner_q;
      take_new = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      if (state_q == IDLE) begin
         if (|req) begin
            win      = rr_pick(req, last_q);
            take_new = 1'b1;
         end
      end else begin
         if (!req[owner_q]) begin
            // Owner released: the old owner becomes the round-robin pointer.
            last_d = owner_q;
            if (|req) begin
               win      = rr_pick(req, owner_q);
               take_new = 1'b1;
            end else begin
               state_d = IDLE;
               grnt_d  = {4{`DISABLE_}};
            end
         end
`ifdef BUS_ARB_TIMEOUT_EN
         else if (cnt_q == c_cnt_max) begin
            // Limit reached: preempt only if someone else is waiting, else saturate.
            if (|others) begin
               last_d   = owner_q;
               win      = rr_pick(others, owner_q);
               take_new = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
`endif
      end
      if (take_new) begin
         owner_d = win;
         state_d = GRANT;
         grnt_d  = grant_vec(win);
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_d   = '0;
`endif
      end
   end

   // State registers with synchronous reset; pointer starts at 3 so master 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd3;
         grnt_q  <= {4{`DISABLE_}};
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grnt_q  <= grnt_d;
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign m0_grnt_ = grnt_q[0];
   assign m1_grnt_ = grnt_q[1];
   assign m2_grnt_ = grnt_q[2];
   assign m3_grnt_ = grnt_q[3];
   assign owner    = owner_q;
   assign busy     = (state_q == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bus_arbiter                                                 |
// | Desc    : Directed self-checking bench for bus_arbiter. Requests and     |
// |           grants are shown as {m3,m2,m1,m0} active-low nibbles.          |
// |           Build with BUS_ARB_TIMEOUT_EN to exercise the hold limit.     |
// | Rev     : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req_n;
   logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   logic [1:0] owner;
   logic       busy;
   int         checks;
   int         errors;

   bus_arbiter #(.ARB_TIMEOUT(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req_  (req_n[0]),
      .m1_req_  (req_n[1]),
      .m2_req_  (req_n[2]),
      .m3_req_  (req_n[3]),
      .m0_grnt_ (m0_grnt_),
      .m1_grnt_ (m1_grnt_),
      .m2_grnt_ (m2_grnt_),
      .m3_grnt_ (m3_grnt_),
      .owner    (owner),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Compare grants, owner and busy against hand-computed values.
   task automatic expect_st(input string tag, input logic [3:0] g, input logic [1:0] own,
                            input logic b);
      chk({tag, "_grnt"},  {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, g);
      chk({tag, "_owner"}, {2'b00, owner}, {2'b00, own});
      chk({tag, "_busy"},  {3'b000, busy}, {3'b000, b});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      req_n  = 4'b1111;
      tick(2);
      reset  = 1'b0;
      expect_st("reset", 4'b1111, 2'd0, 1'b0);

      // Single request from m2: grant appears only after the sampling edge.
      req_n = 4'b1011;
      #1;
      expect_st("m2_pre", 4'b1111, 2'd0, 1'b0);
      tick(1);
      expect_st("m2_grant", 4'b1011, 2'd2, 1'b1);
      req_n = 4'b1111;
      tick(1);
      expect_st("m2_release", 4'b1111, 2'd2, 1'b0);

      // All four request together; each owner drops for one cycle -> 0,1,2,3,0.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      req_n = 4'b0000;
      tick(1);
      expect_st("all_m0", 4'b1110, 2'd0, 1'b1);
      req_n = 4'b0001;
      tick(1);
      expect_st("rr_m1", 4'b1101, 2'd1, 1'b1);
      req_n = 4'b0010;
      tick(1);
      expect_st("rr_m2", 4'b1011, 2'd2, 1'b1);
      req_n = 4'b0100;
      tick(1);
      expect_st("rr_m3", 4'b0111, 2'd3, 1'b1);
      req_n = 4'b1000;
      tick(1);
      expect_st("rr_m0", 4'b1110, 2'd0, 1'b1);

      // m1 owns and holds while m0 and m3 wait; on release m3 wins (scan from 2).
      req_n = 4'b1101;
      tick(1);
      expect_st("own_m1", 4'b1101, 2'd1, 1'b1);
      req_n = 4'b0100;
      tick(3);
      expect_st("hold_m1", 4'b1101, 2'd1, 1'b1);
      req_n = 4'b0110;
      tick(1);
      expect_st("handover_m3", 4'b0111, 2'd3, 1'b1);

      // Release with nobody else requesting, idle 5 cycles, then m0 requests.
      req_n = 4'b1111;
      tick(1);
      expect_st("to_idle", 4'b1111, 2'd3, 1'b0);
      tick(5);
      expect_st("idle_hold", 4'b1111, 2'd3, 1'b0);
      req_n = 4'b1110;
      tick(1);
      expect_st("late_m0", 4'b1110, 2'd0, 1'b1);

      // Reset in the middle of an m3 grant; then m2 beats m3 from the reset pointer.
      req_n = 4'b0111;
      tick(1);
      expect_st("own_m3", 4'b0111, 2'd3, 1'b1);
      reset = 1'b1;
      tick(1);
      expect_st("mid_reset", 4'b1111, 2'd0, 1'b0);
      reset = 1'b0;
      req_n = 4'b0011;
      tick(1);
      expect_st("post_rst_m2", 4'b1011, 2'd2, 1'b1);

      // m2 releases to m3; m2 re-requests alongside m0 and must wait behind m0.
      req_n = 4'b0111;
      tick(1);
      expect_st("m2_to_m3", 4'b0111, 2'd3, 1'b1);
      req_n = 4'b0010;
      tick(1);
      expect_st("m3_holds", 4'b0111, 2'd3, 1'b1);
      req_n = 4'b1010;
      tick(1);
      expect_st("m0_before_m2", 4'b1110, 2'd0, 1'b1);
      req_n = 4'b1011;
      tick(1);
      expect_st("m2_served", 4'b1011, 2'd2, 1'b1);

      // A request dropped before being granted leaves no trace.
      req_n = 4'b1001;
      tick(1);
      expect_st("m1_waits", 4'b1011, 2'd2, 1'b1);
      req_n = 4'b1111;
      tick(1);
      expect_st("m1_dropped", 4'b1111, 2'd2, 1'b0);

      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      req_n = 4'b1110;
      tick(1);
      expect_st("hold_start_m0", 4'b1110, 2'd0, 1'b1);
      req_n = 4'b1100;
`ifdef BUS_ARB_TIMEOUT_EN
      // m0 granted at edge 0; forced off at edge 8 while m1 waits.
      tick(7);
      expect_st("to_edge7", 4'b1110, 2'd0, 1'b1);
      tick(1);
      expect_st("to_edge8", 4'b1101, 2'd1, 1'b1);
      // m1 alone well past the limit keeps the bus; counter saturates.
      req_n = 4'b1101;
      tick(12);
      expect_st("to_saturate", 4'b1101, 2'd1, 1'b1);
      req_n = 4'b1100;
      tick(1);
      expect_st("to_preempt", 4'b1110, 2'd0, 1'b1);
`else
      // Without the hold limit the owner keeps the bus indefinitely.
      tick(20);
      expect_st("no_limit", 4'b1110, 2'd0, 1'b1);
      req_n = 4'b1101;
      tick(1);
      expect_st("no_limit_rel", 4'b1101, 2'd1, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
